// File: rtl/chan_req_agent.sv
`default_nettype none
// ============================================================================
// Module   : chan_req_agent
// Purpose  : Per-channel request/hold/release agent for an active-low
//            acknowledge controller. Optional ack timeout: CHAN_REQ_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module chan_req_agent #(
   parameter int NCH    = 4,
   parameter int HOLD_W = 4,
   parameter int TO_W   = 8
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic [NCH-1:0]    start,
   input  logic [HOLD_W-1:0] hold_len,
   input  logic [NCH-1:0]    ack_n,
   input  logic              clr_err,
   output logic [NCH-1:0]    req,
   output logic [NCH-1:0]    busy,
   output logic [NCH-1:0]    done,
   output logic [NCH-1:0]    err
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQ     = 3'd1,
      ST_HOLD    = 3'd2,
      ST_RELEASE = 3'd3,
      ST_ABORT   = 3'd4
   } state_t;

`ifdef CHAN_REQ_TIMEOUT_EN
   // Last REQ cycle: the increment on this edge would make the count all-ones.
   localparam logic [TO_W-1:0] C_TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
`else
   logic [TO_W-1:0] unused_cfg;
   assign unused_cfg = {TO_W{clr_err}};
   assign err        = '0;
`endif

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      state_t            r_state;
      logic [HOLD_W-1:0] r_hold;
      logic              r_req;
      logic              r_busy;
      logic              r_done;
`ifdef CHAN_REQ_TIMEOUT_EN
      logic [TO_W-1:0]   r_to;
      logic              r_err;
      assign err[i] = r_err;
`endif
      assign req[i]  = r_req;
      assign busy[i] = r_busy;
      assign done[i] = r_done;

      always_ff @(posedge clock or negedge rst_n) begin
         if (!rst_n) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef CHAN_REQ_TIMEOUT_EN
            r_to    <= '0;
            r_err   <= 1'b0;
`endif
         end else begin
            r_done <= 1'b0;
`ifdef CHAN_REQ_TIMEOUT_EN
            // A timeout later in this block overrides the clear.
            if (clr_err) r_err <= 1'b0;
`endif
            case (r_state)
               ST_IDLE: begin
                  if (start[i]) begin
                     r_state <= ST_REQ;
                     r_req   <= 1'b1;
                     r_busy  <= 1'b1;
`ifdef CHAN_REQ_TIMEOUT_EN
                     r_to    <= '0;
`endif
                  end
               end
               ST_REQ: begin
                  if (!ack_n[i]) begin
                     r_state <= ST_HOLD;
                     r_hold  <= hold_len;
                  end
`ifdef CHAN_REQ_TIMEOUT_EN
                  else if (r_to == C_TO_LAST) begin
                     r_state <= ST_ABORT;
                     r_req   <= 1'b0;
                     r_err   <= 1'b1;
                  end else begin
                     r_to <= r_to + 1'b1;
                  end
`endif
               end
               ST_HOLD: begin
                  if (r_hold == '0) begin
                     r_state <= ST_RELEASE;
                     r_req   <= 1'b0;
                  end else begin
                     r_hold <= r_hold - 1'b1;
                  end
               end
               ST_RELEASE: begin
                  if (ack_n[i]) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
`ifdef CHAN_REQ_TIMEOUT_EN
               ST_ABORT: begin
                  if (ack_n[i]) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
`endif
               default: begin
                  r_state <= ST_IDLE;
                  r_req   <= 1'b0;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire
